// File: rtl/rifl_pkg.sv
// Shared RIFL receive-path types: frame-assembly FSM states used by the frame buffer.
package rifl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DISCARD  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rifl_axis_reg_slice.sv
// Full-throughput AXI-Stream register slice: registered m_* outputs plus a one-entry
// skid buffer so s_ready is registered as well.
module rifl_axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             s_take;
  logic             m_free;

  assign s_ready = !skid_valid;
  assign s_take  = s_valid && s_ready;
  assign m_free  = !m_valid || m_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (m_free) begin
      m_valid    <= skid_valid || s_valid;
      skid_valid <= 1'b0;
    end else if (s_take) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (m_free) m_data <= skid_valid ? skid_data : s_data;
    if (!m_free && s_take) skid_data <= s_data;
  end

endmodule

// File: rtl/rifl_rx_frame_buffer.sv
// Receive-side frame buffer: stores incoming AXI-Stream beats and releases a frame to
// the read side only once its tlast beat has been written intact.
module rifl_rx_frame_buffer
  import rifl_pkg::*;
#(
  parameter int DWIDTH        = 240,
  parameter int DEPTH         = 512,
  parameter int PAUSE_ON_VAL  = 2*DEPTH/3,
  parameter int PAUSE_OFF_VAL = DEPTH/3,
  parameter int OUTPUT_REG    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH-1:0]      s_axis_tdata,
  input  logic [DWIDTH/8-1:0]    s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tdrop,
  output logic                   s_axis_tready,
  output logic [DWIDTH-1:0]      m_axis_tdata,
  output logic [DWIDTH/8-1:0]    m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   local_fc,
  output logic                   overflow
);

  localparam int PTR_W  = $clog2(DEPTH) + 1;
  localparam int ADDR_W = PTR_W - 1;
  localparam int KEEP_W = DWIDTH / 8;
  localparam int WORD_W = DWIDTH + KEEP_W + 1;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [WORD_W-1:0] word_t;

  rx_state_e state, state_n;
  ptr_t      wr_ptr, wr_ptr_n;
  ptr_t      commit_ptr, commit_ptr_n;
  ptr_t      rd_ptr, rd_ptr_n;
  logic      full, s_accept, wr_en, ovf_event;
  logic      out_valid, out_ready, pop, load, bypass;
  logic      byp_sel;
  word_t     wr_word, ram_q, byp_q, out_word, m_word;
  word_t     mem [DEPTH];

  assign wr_word       = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign fifo_cnt      = wr_ptr - rd_ptr;
  assign full          = (fifo_cnt == ptr_t'(DEPTH));
  assign s_axis_tready = (state == DISCARD) || !full;
  assign s_accept      = s_axis_tvalid && s_axis_tready;

  // NOTE: every output of this block is defaulted first so no path holds a stale value, which would infer a latch.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    wr_en        = 1'b0;
    ovf_event    = 1'b0;
    case (state)
      IDLE, IN_FRAME: begin
        // An open frame that alone fills the buffer can never commit: abandon it.
        if (state == IN_FRAME && full && commit_ptr == rd_ptr) begin
          wr_ptr_n  = commit_ptr;
          ovf_event = 1'b1;
          state_n   = DISCARD;
        end else if (s_accept) begin
          if (s_axis_tdrop) begin
            wr_ptr_n = commit_ptr;
            state_n  = s_axis_tlast ? IDLE : DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + ptr_t'(1);
            if (s_axis_tlast) begin
              commit_ptr_n = wr_ptr + ptr_t'(1);
              state_n      = IDLE;
            end else begin
              state_n = IN_FRAME;
            end
          end
        end
      end
      DISCARD: begin
        if (s_accept && s_axis_tlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // rd_ptr points at the beat held in the output stage; the slot is released on pop.
  assign pop      = out_valid && out_ready;
  assign rd_ptr_n = rd_ptr + ptr_t'(pop);
  assign load     = (!out_valid || pop) && (rd_ptr_n != commit_ptr_n);
  assign bypass   = wr_en && (wr_ptr == rd_ptr_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      local_fc   <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rd_ptr     <= rd_ptr_n;
      overflow   <= ovf_event;
      if (!out_valid || pop) out_valid <= load;
      if (fifo_cnt > ptr_t'(PAUSE_ON_VAL)) local_fc <= 1'b1;
      else if (fifo_cnt < ptr_t'(PAUSE_OFF_VAL)) local_fc <= 1'b0;
    end
  end

  // NOTE: storage and its read registers carry no reset; out_valid guards them, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
  end

  // A beat committed on the same edge it is fetched is taken from the write port.
  always_ff @(posedge clk) begin
    if (load) begin
      ram_q   <= mem[rd_ptr_n[ADDR_W-1:0]];
      byp_q   <= wr_word;
      byp_sel <= bypass;
    end
  end

  assign out_word = byp_sel ? byp_q : ram_q;

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      rifl_axis_reg_slice #(
        .WIDTH (WORD_W)
      ) u_out_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (out_word),
        .s_valid (out_valid),
        .s_ready (out_ready),
        .m_data  (m_word),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
      );
    end else begin : g_no_reg
      assign m_word        = out_word;
      assign m_axis_tvalid = out_valid;
      assign out_ready     = m_axis_tready;
    end
  endgenerate

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = m_word;

endmodule

// File: tb/tb_rifl_rx_frame_buffer.sv
// Self-checking bench for rifl_rx_frame_buffer (DEPTH=16): directed scenarios plus a
// randomized phase, all compared against a queue-based frame model.
module tb_rifl_rx_frame_buffer;

  localparam int DW     = 32;
  localparam int KW     = DW / 8;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int ON_TH  = 10;
  localparam int OFF_TH = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast, s_tvalid, s_tdrop, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tvalid, m_tready;
  logic [CW-1:0] fifo_cnt;
  logic          local_fc, overflow;

  always #5 clk = ~clk;

  rifl_rx_frame_buffer #(
    .DWIDTH     (DW),
    .DEPTH      (DEPTH),
    .OUTPUT_REG (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdrop  (s_tdrop),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .fifo_cnt      (fifo_cnt),
    .local_fc      (local_fc),
    .overflow      (overflow)
  );

  int    checks = 0;
  int    failures = 0;
  beat_t pend_q[$];
  beat_t comm_q[$];
  bit    discarding = 1'b0;
  bit    fc_exp = 1'b0;
  bit    rand_ready = 1'b0;
  bit    last_acc = 1'b0;
  int    beats_acc = 0;
  int    beats_out = 0;
  int    ovf_pulses = 0;
  int    ovf_at_beat = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes this cycle's handshakes, then DUT outputs are compared mid-cycle.
  task automatic tick();
    int    occ;
    bit    ovf_now, s_acc, m_acc;
    beat_t b;
    if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    occ     = pend_q.size() + comm_q.size();
    ovf_now = !discarding && comm_q.size() == 0 && pend_q.size() == DEPTH;
    s_acc   = s_tvalid && s_tready;
    m_acc   = m_tvalid && m_tready;
    if (m_acc) begin
      comm_q.delete(0);
      beats_out++;
    end
    if (s_acc) begin
      beats_acc++;
      if (discarding) begin
        discarding = !s_tlast;
      end else if (s_tdrop) begin
        pend_q.delete();
        discarding = !s_tlast;
      end else begin
        b.data = s_tdata;
        b.keep = s_tkeep;
        b.last = s_tlast;
        pend_q.push_back(b);
        if (s_tlast) begin
          foreach (pend_q[i]) comm_q.push_back(pend_q[i]);
          pend_q.delete();
        end
      end
    end
    if (ovf_now) begin
      pend_q.delete();
      discarding = 1'b1;
    end
    if (occ > ON_TH) fc_exp = 1'b1;
    else if (occ < OFF_TH) fc_exp = 1'b0;
    last_acc = s_acc;
    @(posedge clk);
    @(negedge clk);
    check("fifo_cnt", 64'(fifo_cnt), 64'(pend_q.size() + comm_q.size()));
    check("s_tready", 64'(s_tready), 64'(discarding || (pend_q.size() + comm_q.size() < DEPTH)));
    check("m_tvalid", 64'(m_tvalid), 64'(comm_q.size() != 0));
    if (comm_q.size() != 0) check("m_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(comm_q[0]));
    check("local_fc", 64'(local_fc), 64'(fc_exp));
    check("overflow", 64'(overflow), 64'(ovf_now));
    if (overflow) begin
      ovf_pulses++;
      ovf_at_beat = beats_acc;
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit drop);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = last;
    s_tdrop  = drop;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    check("beat_accepted", 64'(last_acc), 64'(1));
    s_tvalid = 1'b0;
    s_tdrop  = 1'b0;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) send_beat($urandom, KW'($urandom), i == len - 1, 1'b0);
  endtask

  task automatic drain_to(input int n);
    s_tvalid = 1'b0;
    for (int i = 0; i < 64 && comm_q.size() > n; i++) begin
      m_tready = 1'b1;
      tick();
    end
    m_tready = 1'b0;
    check("drain_cnt", 64'(fifo_cnt), 64'(n));
  endtask

  initial begin
    int out0, acc0, ovf0;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tdrop  = 1'b0;
    m_tready = 1'b0;
    #2;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("rst_local_fc", 64'(local_fc), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 3-beat frame, visible one cycle after the tlast write, delivered in order
    m_tready = 1'b1;
    out0 = beats_out;
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    check("pre_commit_tvalid", 64'(m_tvalid), 64'(0));
    send_beat($urandom, KW'($urandom), 1'b1, 1'b0);
    check("commit_latency", 64'(m_tvalid), 64'(1));
    idle(5);
    check("frame3_out", 64'(beats_out - out0), 64'(3));

    // dropped mid-frame: nothing reaches the read side
    out0 = beats_out;
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b1);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b1, 1'b0);
    check("drop_cnt", 64'(fifo_cnt), 64'(0));
    idle(4);
    check("drop_out", 64'(beats_out - out0), 64'(0));

    // oversize frame: overflow once at beat 16, rest dropped, next frame intact
    m_tready = 1'b0;
    acc0 = beats_acc;
    ovf0 = ovf_pulses;
    send_frame(20);
    check("ovf_pulses", 64'(ovf_pulses - ovf0), 64'(1));
    check("ovf_beat", 64'(ovf_at_beat - acc0), 64'(16));
    check("ovf_cnt", 64'(fifo_cnt), 64'(0));
    m_tready = 1'b1;
    out0 = beats_out;
    send_frame(2);
    idle(5);
    check("after_ovf_out", 64'(beats_out - out0), 64'(2));

    // flow-control hysteresis
    m_tready = 1'b0;
    send_frame(11);
    idle(1);
    check("fc_on", 64'(local_fc), 64'(1));
    drain_to(5);
    idle(2);
    check("fc_hold", 64'(local_fc), 64'(1));
    drain_to(4);
    idle(2);
    check("fc_off", 64'(local_fc), 64'(0));
    drain_to(0);

    // full buffer, then simultaneous read and write
    for (int i = 0; i < DEPTH; i++) send_beat($urandom, KW'($urandom), 1'b1, 1'b0);
    check("full_cnt", 64'(fifo_cnt), 64'(DEPTH));
    check("full_tready", 64'(s_tready), 64'(0));
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat($urandom, KW'($urandom), 1'b1, 1'b0);
      check("rw_cnt", 64'(fifo_cnt), 64'(DEPTH - 1));
      check("rw_tready", 64'(s_tready), 64'(1));
    end
    drain_to(0);

    // reset with an open frame
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    send_beat($urandom, KW'($urandom), 1'b0, 1'b0);
    check("pre_rst_cnt", 64'(fifo_cnt), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("mid_rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("mid_rst_local_fc", 64'(local_fc), 64'(0));
    check("mid_rst_overflow", 64'(overflow), 64'(0));
    check("mid_rst_s_tready", 64'(s_tready), 64'(1));
    pend_q.delete();
    comm_q.delete();
    discarding = 1'b0;
    fc_exp     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    out0 = beats_out;
    send_frame(1);
    idle(4);
    check("post_rst_out", 64'(beats_out - out0), 64'(1));

    // randomized frames, drops, gaps and read backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len, drop_at;
      len     = (f % 13 == 12) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 8));
      drop_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat($urandom, KW'($urandom), b == len - 1, b == drop_at);
      end
    end
    rand_ready = 1'b0;
    drain_to(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rifl_rx_frame_buffer.md
RIFL_RX_FRAME_BUFFER -- requirements
Module: rifl_rx_frame_buffer

Interface
REQ-001 SHALL have parameter DWIDTH, default 240, meaning payload width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 512, meaning entries (power of 2, >=4).
REQ-003 SHALL have parameter PAUSE_ON_VAL, default 2*DEPTH/3, meaning occupancy above which local_fc asserts.
REQ-004 SHALL have parameter PAUSE_OFF_VAL, default DEPTH/3, meaning occupancy below which local_fc deasserts (< PAUSE_ON_VAL).
REQ-005 SHALL have parameter OUTPUT_REG, default 0, meaning 1 adds one output register stage.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports s_axis_tdata/tkeep/tlast/tvalid, input, DWIDTH/DWIDTH/8/1/1, write-side beats; s_axis_tready, output, 1.
REQ-009 SHALL have port s_axis_tdrop, input, 1, qualified by tvalid, meaning abort the current frame.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tlast/tvalid, output, read side; m_axis_tready, input, 1.
REQ-011 SHALL have port fifo_cnt, output, $clog2(DEPTH)+1, total occupancy (committed + uncommitted).
REQ-012 SHALL have ports local_fc, output, 1, hysteretic pause request; overflow, output, 1, one-cycle pulse.

Function
REQ-013 SHALL keep rd_ptr, commit_ptr, and wr_ptr, each $clog2(DEPTH)+1 bits, with wrap by natural overflow; full when wr_ptr-rd_ptr == DEPTH.
REQ-014 SHALL expose only committed entries to the read side: m_axis_tvalid requires rd_ptr != commit_ptr.
REQ-015 SHALL accept a beat when tvalid&&tready; s_axis_tready = !full in IDLE/IN_FRAME, and 1 in DISCARD.
REQ-016 SHALL run an FSM with states IDLE (no open frame), IN_FRAME (uncommitted beats stored), and DISCARD (dropping until tlast).
REQ-017 SHALL, on an accepted beat with tlast=1 and tdrop=0, store it and set commit_ptr to the new wr_ptr in the same cycle, then go to IDLE.
REQ-018 SHALL, on an accepted beat with tdrop=1, not store the beat, restore wr_ptr to commit_ptr, and go to IDLE if tlast=1, else DISCARD.
REQ-019 SHALL, when full and commit_ptr == rd_ptr (buffer holds one oversize frame), restore wr_ptr to commit_ptr, pulse overflow, and go to DISCARD.
REQ-020 SHALL, in DISCARD, accept and drop all beats; the beat with tlast returns the FSM to IDLE.
REQ-021 SHALL have commit-to-visible latency of 1 cycle (m_axis_tvalid high the cycle after the tlast write), or 2 cycles with OUTPUT_REG=1.
REQ-022 SHALL allow a simultaneous read and write in one cycle; fifo_cnt stays unchanged in that case.
REQ-023 SHALL hold m_axis_* stable while tvalid && !tready (AXIS rule).
REQ-024 SHALL set local_fc when fifo_cnt > PAUSE_ON_VAL, clear it when fifo_cnt < PAUSE_OFF_VAL, and hold it otherwise; these are registered updates.
REQ-025 SHALL use restored occupancy in the same-cycle fifo_cnt when a rollback (REQ-018/019) occurs.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all pointers, set FSM to IDLE, and drive m_axis_tvalid=0, local_fc=0, overflow=0, and fifo_cnt=0.
REQ-027 SHALL discard any open frame on reset mid-frame; the first beat after reset starts a new frame.
REQ-028 SHALL leave memory contents unreset.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, IN_FRAME, DISCARD) in the shared rifl_pkg.
REQ-030 SHALL derive the pointer-width localparam as $clog2(DEPTH)+1 locally.
REQ-031 SHALL implement OUTPUT_REG as one sub-module, rifl_axis_reg_slice (DWIDTH+DWIDTH/8+1 bits, full-throughput).
REQ-032 SHALL infer storage as a simple dual-port RAM with a registered read.

Verification
REQ-033 SHALL cover: DEPTH=16, write a 3-beat frame with tlast, m_axis_tready=1 -> 3 beats out, first tvalid at 1 cycle after the tlast write, data in order.
REQ-034 SHALL cover: 2 beats, then a 3rd beat with tdrop=1 and tlast=0, then 2 more beats with the last tlast -> nothing output, fifo_cnt=0 after the tlast beat.
REQ-035 SHALL cover: DEPTH=16, a 20-beat frame with m_axis_tready=0 -> overflow pulses once at beat 16, the remaining 4 beats are accepted and dropped, fifo_cnt=0, and the next 2-beat frame is delivered intact.
REQ-036 SHALL cover: DEPTH=16 (ON=10, OFF=5), fill 11 committed beats -> local_fc=1; drain to 5 -> still 1; drain to 4 -> local_fc=0.
REQ-037 SHALL cover: full buffer with committed data, read and write in the same cycle -> fifo_cnt constant, tready stays asserted, no data loss.
REQ-038 SHALL cover: rst_n pulsed low mid-frame with 3 uncommitted beats -> all outputs at reset values immediately, and a subsequent 1-beat frame is delivered alone.
